// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared types and address-field positions for the DRAM command scheduler.
package mem_sched_pkg;

  typedef enum logic [1:0] {
    CMD_PRE = 2'd0,
    CMD_ACT = 2'd1,
    CMD_RD  = 2'd2,
    CMD_WR  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_IFETCH = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECIDE    = 3'd1,
    S_PRE       = 3'd2,
    S_WAIT_RP   = 3'd3,
    S_ACT       = 3'd4,
    S_WAIT_RCD  = 3'd5,
    S_RW        = 3'd6,
    S_WAIT_DATA = 3'd7
  } state_e;

  // Byte address layout: [31:18] row, [17:10] column, [9:6] bank, [5:0] ignored.
  localparam int BANK_LSB = 6;
  localparam int BANK_W   = 4;
  localparam int COL_LSB  = 10;
  localparam int COL_W    = 8;
  localparam int ROW_LSB  = 18;
  localparam int ROW_W    = 14;
  localparam int CNT_W    = 8;

  typedef struct packed {
    op_e               op;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
  } req_t;

endpackage

// File: rtl/sched_req_fifo.sv
// sched_req_fifo: synchronous in-order request queue; head entry is visible combinationally.
module sched_req_fifo
  import mem_sched_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  req_t          push_data,
  input  logic          pop,
  output req_t          head,
  output logic          empty,
  output logic [CW-1:0] count
);

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push while full is dropped rather than overwriting the oldest entry.
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_cmd_scheduler.sv
// mem_cmd_scheduler: in-order PRE/ACT/RD/WR sequencer with open-page policy and per-bank row tracking.
// Define MEM_SCHED_STATS_EN to add saturating hit/miss/conflict counters.
module mem_cmd_scheduler
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int QDEPTH    = 16,
  parameter int NUM_BANKS = 16,
  parameter int T_RP      = 24,
  parameter int T_RCD     = 24,
  parameter int T_CL      = 24,
  parameter int T_CWL     = 20,
  parameter int T_BURST   = 4,
  localparam int QCW = $clog2(QDEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              cmd_valid,
  output logic [1:0]        cmd_type,
  output logic [3:0]        cmd_bank,
  output logic [13:0]       cmd_row,
  output logic [7:0]        cmd_col,
  output logic              done,
  output logic [QCW-1:0]    q_count,
`ifdef MEM_SCHED_STATS_EN
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_conflicts,
`endif
  output state_e            dbg_state
);

  if (T_RP < 2 || T_RP > 255 || T_RCD < 2 || T_RCD > 255 || T_BURST < 1 ||
      T_CL > 255 || T_CWL > 255 || T_BURST > 255 ||
      T_CL + T_BURST > 256 || T_CWL + T_BURST > 256) begin : g_bad_timing
    $error("mem_cmd_scheduler: timing parameter outside 8-bit counter range");
  end
  if (ADDR_W < 32 || NUM_BANKS != (1 << BANK_W) ||
      QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_geometry
    $error("mem_cmd_scheduler: unsupported address width, bank count or queue depth");
  end

  // Wait states exit at zero and the following command state adds one more cycle,
  // so loading T-2 places the next command exactly T cycles after PRE/ACT.
  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 2);
  localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 2);
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(T_CL + T_BURST - 1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(T_CWL + T_BURST - 1);

  state_e            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  req_t              push_data, head;
  logic              push, pop, q_empty;
  logic              cmd_issue;
  cmd_e              cmd_kind;
  logic [1:0]        cmd_type_q;
  logic [3:0]        cmd_bank_q;
  logic [13:0]       cmd_row_q;
  logic [7:0]        cmd_col_q;
  logic [NUM_BANKS-1:0] bank_open;
  logic [ROW_W-1:0]  bank_row [NUM_BANKS];
  logic              bank_hit, bank_conflict;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^req_addr[BANK_LSB-1:0];

  // Reserved ops are handshaked like any request but never enter the queue.
  assign req_ready = (q_count != QCW'(QDEPTH));
  assign push      = req_valid && req_ready && (op_e'(req_op) != OP_RSVD);
  assign push_data = '{op:   op_e'(req_op),
                       bank: req_addr[BANK_LSB +: BANK_W],
                       row:  req_addr[ROW_LSB +: ROW_W],
                       col:  req_addr[COL_LSB +: COL_W]};

  sched_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign bank_hit      = bank_open[head.bank] && (bank_row[head.bank] == head.row);
  assign bank_conflict = bank_open[head.bank] && (bank_row[head.bank] != head.row);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    cmd_issue = 1'b0;
    cmd_kind  = CMD_PRE;
    done      = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE:     if (!q_empty) state_nx = S_DECIDE;
      S_DECIDE: begin
        if (bank_hit)           state_nx = S_RW;
        else if (bank_conflict) state_nx = S_PRE;
        else                    state_nx = S_ACT;
      end
      S_PRE: begin
        cmd_issue = 1'b1;
        cmd_kind  = CMD_PRE;
        cnt_nx    = RP_LOAD;
        state_nx  = S_WAIT_RP;
      end
      S_WAIT_RP:  if (cnt == '0) state_nx = S_ACT;
      S_ACT: begin
        cmd_issue = 1'b1;
        cmd_kind  = CMD_ACT;
        cnt_nx    = RCD_LOAD;
        state_nx  = S_WAIT_RCD;
      end
      S_WAIT_RCD: if (cnt == '0) state_nx = S_RW;
      S_RW: begin
        cmd_issue = 1'b1;
        cmd_kind  = (head.op == OP_WRITE) ? CMD_WR : CMD_RD;
        cnt_nx    = (head.op == OP_WRITE) ? WR_LOAD : RD_LOAD;
        state_nx  = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (cnt == '0) begin
          done     = 1'b1;
          pop      = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default:    state_nx = S_IDLE;
    endcase
  end

  // Open-row table: PRE closes the head's bank, ACT opens it on the head's row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_open <= '0;
      for (int i = 0; i < NUM_BANKS; i++) bank_row[i] <= '0;
    end else if (state == S_PRE) begin
      bank_open[head.bank] <= 1'b0;
    end else if (state == S_ACT) begin
      bank_open[head.bank] <= 1'b1;
      bank_row[head.bank]  <= head.row;
    end
  end

  // Command fields show the live command while strobing and hold the last one otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_type_q <= '0;
      cmd_bank_q <= '0;
      cmd_row_q  <= '0;
      cmd_col_q  <= '0;
    end else if (cmd_issue) begin
      cmd_type_q <= cmd_kind;
      cmd_bank_q <= head.bank;
      cmd_row_q  <= head.row;
      cmd_col_q  <= head.col;
    end
  end

  assign cmd_valid = cmd_issue;
  assign cmd_type  = cmd_issue ? cmd_kind  : cmd_type_q;
  assign cmd_bank  = cmd_issue ? head.bank : cmd_bank_q;
  assign cmd_row   = cmd_issue ? head.row  : cmd_row_q;
  assign cmd_col   = cmd_issue ? head.col  : cmd_col_q;
  assign dbg_state = state;

`ifdef MEM_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits      <= '0;
      stat_misses    <= '0;
      stat_conflicts <= '0;
    end else if (state == S_DECIDE) begin
      if (bank_hit) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      end else if (bank_conflict) begin
        if (stat_conflicts != '1) stat_conflicts <= stat_conflicts + 32'd1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule
